// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry 2-bit counters,
// plus a gshare PHT/GHR pair, selectable by MODE, with a saturating mispredict counter.
module branch_predictor #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned MODE       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_if,
    output logic                 predict_taken,
    output logic [WORD_SIZE-1:0] predict_target,
    output logic [WORD_SIZE-1:0] next_pc,
    input  logic                 update_valid,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic                 update_is_cond,
    input  logic                 update_taken,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_pred_taken,
    input  logic [WORD_SIZE-1:0] update_pred_target,
    output logic [WORD_SIZE-1:0] mispredict_count
);
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = WORD_SIZE - INDEX_BITS;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0]  target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];
    logic [1:0]            pht_q    [ENTRIES];
    logic [INDEX_BITS-1:0] ghr_q;
    logic [WORD_SIZE-1:0]  count_q;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Lookup path
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag_if;
    logic                  hit;

    assign idx    = pc_if[INDEX_BITS-1:0];
    assign tag_if = pc_if[WORD_SIZE-1:INDEX_BITS];
    assign hit    = valid_q[idx] && (tag_q[idx] == tag_if);

    always_comb begin
        predict_taken = 1'b0;
        case (MODE)
            1:       predict_taken = hit;
            2:       predict_taken = hit && ctr_q[idx][1];
            3:       predict_taken = hit && pht_q[idx ^ ghr_q][1];
            default: predict_taken = 1'b0;
        endcase
    end

    assign predict_target   = hit ? target_q[idx] : '0;
    assign next_pc          = predict_taken ? predict_target
                                            : pc_if + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    assign mispredict_count = count_q;

    // Update path
    logic [INDEX_BITS-1:0] upd_idx;
    logic [INDEX_BITS-1:0] pht_idx;
    logic                  upd_hit;
    logic                  eff_taken;
    logic                  mispredict;
    logic                  entry_we;
    logic                  ctr_we;
    logic [1:0]            ctr_d;
    logic [INDEX_BITS:0]   ghr_shift;

    assign upd_idx    = update_pc[INDEX_BITS-1:0];
    assign pht_idx    = upd_idx ^ ghr_q;
    assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == update_pc[WORD_SIZE-1:INDEX_BITS]);
    assign eff_taken  = update_taken | ~update_is_cond;
    assign mispredict = update_valid && ((update_pred_taken != eff_taken) ||
                        (eff_taken && (update_pred_target != update_target)));
    assign ghr_shift  = {ghr_q, update_taken};

    always_comb begin
        entry_we = 1'b0;
        ctr_we   = 1'b0;
        ctr_d    = ctr_q[upd_idx];
        if (!update_is_cond) begin
            entry_we = 1'b1;
            ctr_we   = 1'b1;
            ctr_d    = 2'b11;
        end else if (update_taken) begin
            entry_we = 1'b1;
            ctr_we   = 1'b1;
            ctr_d    = upd_hit ? ctr_next(ctr_q[upd_idx], 1'b1) : 2'b10;
        end else if (upd_hit) begin
            // Not-taken hit only trains the counter; target and tag stay.
            ctr_we = 1'b1;
            ctr_d  = ctr_next(ctr_q[upd_idx], 1'b0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                pht_q[i]    <= 2'b01;
            end
            ghr_q   <= '0;
            count_q <= '0;
        end else if (update_valid) begin
            if (entry_we) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= update_pc[WORD_SIZE-1:INDEX_BITS];
                target_q[upd_idx] <= update_target;
            end
            if (ctr_we) begin
                ctr_q[upd_idx] <= ctr_d;
            end
            if (update_is_cond) begin
                pht_q[pht_idx] <= ctr_next(pht_q[pht_idx], update_taken);
                ghr_q          <= ghr_shift[INDEX_BITS-1:0];
            end
            if (mispredict && (count_q != '1)) begin
                count_q <= count_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: four mode instances share one update bus; a narrow instance
// exercises mispredict counter saturation.
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [15:0] pc_if;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_is_cond;
    logic        update_taken;
    logic [15:0] update_target;
    logic        update_pred_taken;
    logic [15:0] update_pred_target;

    logic        pt0, pt1, pt2, pt3;
    logic [15:0] tg0, tg1, tg2, tg3;
    logic [15:0] np0, np1, np2, np3;
    logic [15:0] mc0, mc1, mc2, mc3;

    logic [3:0]  s_pc;
    logic        s_valid;
    logic        s_pt;
    logic [3:0]  s_tg, s_np, s_mc;

    int vectors = 0;
    int errors  = 0;

    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken(pt0), .predict_target(tg0), .next_pc(np0),
        .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
        .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .mispredict_count(mc0)
    );
    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken(pt1), .predict_target(tg1), .next_pc(np1),
        .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
        .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .mispredict_count(mc1)
    );
    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(2)) u_m2 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken(pt2), .predict_target(tg2), .next_pc(np2),
        .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
        .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .mispredict_count(mc2)
    );
    branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .MODE(3)) u_m3 (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken(pt3), .predict_target(tg3), .next_pc(np3),
        .update_valid(update_valid), .update_pc(update_pc), .update_is_cond(update_is_cond),
        .update_taken(update_taken), .update_target(update_target),
        .update_pred_taken(update_pred_taken), .update_pred_target(update_pred_target),
        .mispredict_count(mc3)
    );
    branch_predictor #(.WORD_SIZE(4), .INDEX_BITS(2), .MODE(1)) u_small (
        .clk(clk), .reset(reset), .pc_if(s_pc),
        .predict_taken(s_pt), .predict_target(s_tg), .next_pc(s_np),
        .update_valid(s_valid), .update_pc(4'h1), .update_is_cond(1'b0),
        .update_taken(1'b0), .update_target(4'h2),
        .update_pred_taken(1'b0), .update_pred_target(4'h0),
        .mispredict_count(s_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] pc, input logic cond, input logic tkn,
                         input logic [15:0] tgt, input logic ptkn, input logic [15:0] ptgt);
        update_valid       = 1'b1;
        update_pc          = pc;
        update_is_cond     = cond;
        update_taken       = tkn;
        update_target      = tgt;
        update_pred_taken  = ptkn;
        update_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
    endtask

    logic exp_m3 [8];
    logic exp_m2 [8];

    initial begin
        exp_m3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_m2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        pc_if = 16'h0010;
        s_pc = 4'h0;
        s_valid = 1'b0;
        drive(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        update_valid = 1'b0;
        #1;
        chk("rst_taken", {15'b0, pt2}, 16'h0000);
        chk("rst_target", tg2, 16'h0000);
        chk("rst_next", np2, 16'h0011);
        chk("rst_m3_taken", {15'b0, pt3}, 16'h0000);
        chk("rst_count", mc2, 16'h0000);
        pc_if = 16'hFFFF;
        #1;
        chk("wrap_next_m2", np2, 16'h0000);
        chk("wrap_next_m0", np0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        pc_if = 16'h0010;

        // First taken update; same-cycle lookup must still see the old state.
        drive(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000);
        #1;
        chk("same_cycle_pre", {15'b0, pt2}, 16'h0000);
        tick();
        chk("trainA_taken", {15'b0, pt2}, 16'h0001);
        chk("trainA_next", np2, 16'h0040);
        chk("trainA_count", mc2, 16'h0001);
        chk("trainA_m0_next", np0, 16'h0011);
        chk("trainA_m1_taken", {15'b0, pt1}, 16'h0001);
        chk("trainA_m3_taken", {15'b0, pt3}, 16'h0000);

        drive(16'h0010, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040);
        tick();
        drive(16'h0010, 1'b1, 1'b0, 16'h0040, 1'b0, 16'h0040);
        tick();
        chk("nt2_taken", {15'b0, pt2}, 16'h0000);
        chk("nt2_next", np2, 16'h0011);
        chk("nt2_target", tg2, 16'h0040);
        chk("nt2_count", mc2, 16'h0002);
        chk("nt2_m1_next", np1, 16'h0040);

        for (int i = 0; i < 6; i++) begin
            drive(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0040);
            tick();
        end
        drive(16'h0010, 1'b1, 1'b0, 16'h0040, 1'b1, 16'h0040);
        tick();
        chk("sat_taken", {15'b0, pt2}, 16'h0001);
        chk("sat_next", np2, 16'h0040);
        chk("sat_count", mc2, 16'h0003);
        chk("sat_m3_taken", {15'b0, pt3}, 16'h0000);

        pc_if = 16'h0050;
        #1;
        chk("alias_miss_taken", {15'b0, pt2}, 16'h0000);
        chk("alias_miss_target", tg2, 16'h0000);
        chk("alias_miss_next", np2, 16'h0051);
        drive(16'h0050, 1'b0, 1'b0, 16'h0100, 1'b0, 16'h0000);
        tick();
        chk("jump_next", np2, 16'h0100);
        chk("jump_m1_taken", {15'b0, pt1}, 16'h0001);
        chk("jump_m0_next", np0, 16'h0051);
        chk("jump_m0_target", tg0, 16'h0100);
        chk("jump_count", mc2, 16'h0004);
        pc_if = 16'h0010;
        #1;
        chk("evicted_taken", {15'b0, pt2}, 16'h0000);
        chk("evicted_target", tg2, 16'h0000);
        chk("evicted_next", np2, 16'h0011);

        // Reset between edges with a coincident update that must be dropped.
        pc_if = 16'h0050;
        reset = 1'b1;
        drive(16'h0007, 1'b1, 1'b1, 16'h0030, 1'b0, 16'h0000);
        #1;
        chk("midrst_taken", {15'b0, pt2}, 16'h0000);
        chk("midrst_next", np2, 16'h0051);
        chk("midrst_target", tg2, 16'h0000);
        chk("midrst_count", mc2, 16'h0000);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        pc_if = 16'h0007;
        #1;
        chk("midrst_nowrite_m1", {15'b0, pt1}, 16'h0000);
        chk("midrst_nowrite_tgt", tg2, 16'h0000);
        chk("midrst_count2", mc2, 16'h0000);

        // Gshare from clean state: alternating T/NT at 0x0005.
        pc_if = 16'h0005;
        for (int i = 0; i < 8; i++) begin
            drive(16'h0005, 1'b1, (i % 2 == 0), 16'h0020, 1'b0, 16'h0000);
            tick();
            chk($sformatf("gs_m3_taken_%0d", i), {15'b0, pt3}, {15'b0, exp_m3[i]});
            chk($sformatf("gs_m2_taken_%0d", i), {15'b0, pt2}, {15'b0, exp_m2[i]});
        end
        chk("gs_m3_next", np3, 16'h0020);
        chk("gs_count", mc3, 16'h0004);
        drive(16'h0005, 1'b0, 1'b0, 16'h0020, 1'b0, 16'h0000);
        tick();
        chk("gs_jump_keeps_ghr", {15'b0, pt3}, 16'h0001);
        chk("gs_jump_count", mc3, 16'h0005);
        drive(16'h0005, 1'b1, 1'b1, 16'h0020, 1'b1, 16'h0021);
        tick();
        chk("target_mismatch_count", mc3, 16'h0006);

        s_valid = 1'b1;
        for (int i = 0; i < 14; i++) @(posedge clk);
        #1;
        chk("small_count_14", {12'b0, s_mc}, 16'h000E);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("small_count_sat", {12'b0, s_mc}, 16'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
